// File: rtl/bp_me_mem_cmd_arbiter_pkg.sv
// Shared types and widths for the memory-command arbiter.
// The arbiter state enum is also used by the planned response demux.
package bp_me_mem_cmd_arbiter_pkg;

  localparam int paddr_width_p     = 40;
  localparam int lce_id_width_p    = 4;
  localparam int lce_assoc_p       = 8;
  localparam int cce_block_width_p = 512;

  // msg_type, subop, addr, size, lce_id, way_id
  localparam int cce_mem_header_width_lp =
    4 + 4 + paddr_width_p + 3 + lce_id_width_p + $clog2(lce_assoc_p);

  typedef enum logic {
    e_idle,
    e_lock
  } bp_me_mem_arb_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_me_mem_arb_rr_pick.sv
// Rotate-priority picker: first set request at or above the
// pointer, wrapping modulo num_req_p.
module bp_me_mem_arb_rr_pick
  import bp_me_mem_cmd_arbiter_pkg::*;
#(
  parameter int num_req_p = 2,
  localparam int lg_lp = safe_clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [lg_lp-1:0]     ptr_i,
  output logic [lg_lp-1:0]     idx_o,
  output logic                 found_o
);

  int k;

  // With no request the index falls back to the pointer itself.
  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    k       = 0;
    for (int i = 0; i < num_req_p; i++) begin
      k = (int'(ptr_i) + i) % num_req_p;
      if (!found_o && req_i[k]) begin
        found_o = 1'b1;
        idx_o   = k[lg_lp-1:0];
      end
    end
  end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Message-atomic round-robin arbiter of N memory-command streams.
// Define BP_ME_MEM_ARB_WATCHDOG_EN to build the lock-stall watchdog.
module bp_me_mem_cmd_arbiter
  import bp_me_mem_cmd_arbiter_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int data_width_p      = 64,
  parameter int watchdog_cycles_p = 1024,
  localparam int lg_num_req_lp    = safe_clog2(num_req_p),
  localparam int header_width_lp  = cce_mem_header_width_lp
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p*header_width_lp-1:0] mem_header_i,
  input  logic [num_req_p*data_width_p-1:0]    mem_data_i,
  input  logic [num_req_p-1:0]                 mem_v_i,
  input  logic [num_req_p-1:0]                 mem_last_i,
  output logic [num_req_p-1:0]                 mem_ready_and_o,
  output logic [header_width_lp-1:0]           mem_header_o,
  output logic [data_width_p-1:0]              mem_data_o,
  output logic                                 mem_v_o,
  output logic                                 mem_last_o,
  input  logic                                 mem_ready_and_i,
  output logic [lg_num_req_lp-1:0]             grant_id_o,
  output logic                                 error_o
);

  if (num_req_p < 2 || num_req_p > 8 || watchdog_cycles_p < 1)
  begin : g_bad_cfg
    $error("bp_me_mem_cmd_arbiter: bad parameters");
  end

  bp_me_mem_arb_state_e state_q, state_d;
  logic [lg_num_req_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [lg_num_req_lp-1:0] lock_id_q, lock_id_d;
  logic [lg_num_req_lp-1:0] winner, sel;
  logic found, v_sel, xfer;

  bp_me_mem_arb_rr_pick #(
    .num_req_p(num_req_p)
  ) pick (
    .req_i  (mem_v_i),
    .ptr_i  (rr_ptr_q),
    .idx_o  (winner),
    .found_o(found)
  );

  function automatic logic [lg_num_req_lp-1:0] rr_next(
    input logic [lg_num_req_lp-1:0] x
  );
    if (int'(x) >= num_req_p - 1) return '0;
    return x + 1'b1;
  endfunction

  assign sel        = (state_q == e_lock) ? lock_id_q : winner;
  assign grant_id_o = sel;

  always_comb begin
    mem_header_o    = '0;
    mem_data_o      = '0;
    mem_last_o      = 1'b0;
    v_sel           = 1'b0;
    mem_ready_and_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (i == int'(sel)) begin
        mem_header_o = mem_header_i[i*header_width_lp +: header_width_lp];
        mem_data_o   = mem_data_i[i*data_width_p +: data_width_p];
        mem_last_o   = mem_last_i[i];
        v_sel        = mem_v_i[i];
        mem_ready_and_o[i] = mem_ready_and_i & ~reset_i;
      end
    end
    mem_v_o = ~reset_i & ((state_q == e_lock) ? v_sel : found);
  end

  assign xfer = mem_v_o & mem_ready_and_i;

  // Pointer update on the last beat overlaps the next arbitration.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (xfer) begin
      if (mem_last_o) begin
        state_d  = e_idle;
        rr_ptr_d = rr_next(sel);
      end else if (state_q == e_idle) begin
        state_d   = e_lock;
        lock_id_d = sel;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

`ifdef BP_ME_MEM_ARB_WATCHDOG_EN
  localparam int wd_width_lp = safe_clog2(watchdog_cycles_p + 1);
  localparam logic [wd_width_lp-1:0] wd_max_lp =
    wd_width_lp'(watchdog_cycles_p);

  logic [wd_width_lp-1:0] wd_cnt_q, wd_cnt_d;
  logic error_q, error_d;

  // Counts stalled cycles while locked; saturates at the limit.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == e_lock && !xfer) begin
      wd_cnt_d = (wd_cnt_q == wd_max_lp) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
    error_d = error_q | (wd_cnt_d == wd_max_lp);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      error_q  <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Randomized scoreboard bench for the memory-command arbiter
// (3 requesters, 8-cycle watchdog limit).
module tb_bp_me_mem_cmd_arbiter;
  import bp_me_mem_cmd_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int DW = 64;
  localparam int HW = cce_mem_header_width_lp;
  localparam int LG = safe_clog2(NR);
`ifdef BP_ME_MEM_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  typedef struct {
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [NR*HW-1:0] mem_header_i;
  logic [NR*DW-1:0] mem_data_i;
  logic [NR-1:0]   mem_v_i, mem_last_i, mem_ready_and_o;
  logic [HW-1:0]   mem_header_o;
  logic [DW-1:0]   mem_data_o;
  logic            mem_v_o, mem_last_o, mem_ready_and_i, error_o;
  logic [LG-1:0]   grant_id_o;

  bp_me_mem_cmd_arbiter #(
    .num_req_p(NR), .data_width_p(DW), .watchdog_cycles_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .mem_header_i(mem_header_i), .mem_data_i(mem_data_i),
    .mem_v_i(mem_v_i), .mem_last_i(mem_last_i),
    .mem_ready_and_o(mem_ready_and_o),
    .mem_header_o(mem_header_o), .mem_data_o(mem_data_o),
    .mem_v_o(mem_v_o), .mem_last_o(mem_last_o),
    .mem_ready_and_i(mem_ready_and_i),
    .grant_id_o(grant_id_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  beat_t src_q[NR][$];
  beat_t exp_q[NR][$];
  logic [NR-1:0] acc;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic drive(input int k, input beat_t b, input logic v);
    mem_header_i[k*HW +: HW] = b.hdr;
    mem_data_i[k*DW +: DW]   = b.data;
    mem_last_i[k]            = b.last;
    mem_v_i[k]               = v;
  endtask

  function automatic beat_t mk(input logic [HW-1:0] h, input logic l);
    beat_t b;
    b.hdr  = h;
    b.data = {$urandom, $urandom};
    b.last = l;
    return b;
  endfunction

  task automatic push_msg(input int k, input int len, input bit to_src);
    logic [HW-1:0] h;
    beat_t b;
    h = HW'({$urandom, $urandom});
    for (int j = 0; j < len; j++) begin
      b = mk(h, j == len - 1);
      exp_q[k].push_back(b);
      if (to_src) src_q[k].push_back(b);
    end
  endtask

  // One driver cycle: retire accepted beats, maybe start new messages.
  task automatic step(input bit gen, input bit bub);
    beat_t b;
    for (int k = 0; k < NR; k++) begin
      if (acc[k]) void'(src_q[k].pop_front());
      if (gen && src_q[k].size() == 0 && $urandom_range(0, 2) == 0)
        push_msg(k, $urandom_range(1, 4), 1'b1);
      if (src_q[k].size() != 0) begin
        b = src_q[k][0];
        drive(k, b, !(bub && $urandom_range(0, 9) == 0));
      end else begin
        mem_v_i[k] = 1'b0;
      end
    end
    mem_ready_and_i = bub ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // Reference: round-robin on message boundaries, lock while mid-message.
  int  m_ptr = 0;
  int  m_lk = 0;
  bit  m_locked = 1'b0;
  int  m_sel, m_k;
  bit  m_found, m_ev;
  beat_t m_b;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_i) begin
        m_ptr = 0;
        m_locked = 1'b0;
        chk("rst_v_o", 128'(mem_v_o), 128'(0));
        chk("rst_ready_o", 128'(mem_ready_and_o), 128'(0));
        continue;
      end
      m_found = 1'b0;
      m_sel = m_ptr;
      for (int i = 0; i < NR; i++) begin
        m_k = (m_ptr + i) % NR;
        if (!m_found && mem_v_i[m_k]) begin
          m_found = 1'b1;
          m_sel = m_k;
        end
      end
      if (m_locked) m_sel = m_lk;
      m_ev = m_locked ? mem_v_i[m_lk] : m_found;
      chk("grant_id", 128'(grant_id_o), 128'(m_sel));
      chk("v_o", 128'(mem_v_o), 128'(m_ev));
      chk("ready_o", 128'(mem_ready_and_o),
          mem_ready_and_i ? 128'(1) << m_sel : 128'(0));
      if (m_ev) begin
        if (exp_q[m_sel].size() == 0) begin
          chk("unexpected_beat", 128'(1), 128'(0));
        end else begin
          m_b = exp_q[m_sel][0];
          chk("header", 128'(mem_header_o), 128'(m_b.hdr));
          chk("data", 128'(mem_data_o), 128'(m_b.data));
          chk("last", 128'(mem_last_o), 128'(m_b.last));
          if (mem_ready_and_i) begin
            void'(exp_q[m_sel].pop_front());
            if (m_b.last) begin
              m_locked = 1'b0;
              m_ptr = (m_sel + 1) % NR;
            end else begin
              m_locked = 1'b1;
              m_lk = m_sel;
            end
          end
        end
      end
    end
  end

  int left;
  beat_t b0, b1, c0;
  logic [HW-1:0] hh;

  initial begin
    reset_i = 1'b1;
    mem_ready_and_i = 1'b1;
    mem_header_i = '0;
    mem_data_i = '0;
    mem_last_i = '0;
    mem_v_i = '1;
    acc = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    mem_v_i = '0;
    @(negedge clk);
    chk("err_after_reset", 128'(error_o), 128'(0));
    chk("grant_idle_reset", 128'(grant_id_o), 128'(0));

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = mem_v_i & mem_ready_and_o;
      @(posedge clk);
      #1;
      step(1'b1, c >= 200 || c % 50 > 25);
    end

    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = mem_v_i & mem_ready_and_o;
      @(posedge clk);
      #1;
      step(1'b0, 1'b0);
    end
    left = 0;
    for (int k = 0; k < NR; k++) left += exp_q[k].size() + src_q[k].size();
    chk("drain_left", 128'(left), 128'(0));
    mem_v_i = '0;
    for (int k = 0; k < NR; k++) begin
      exp_q[k].delete();
      src_q[k].delete();
    end

    @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    mem_ready_and_i = 1'b1;
    hh = HW'({$urandom, $urandom});
    b0 = mk(hh, 1'b0);
    b1 = mk(hh, 1'b1);
    exp_q[1].push_back(b0);
    exp_q[1].push_back(b1);
    drive(1, b0, 1'b1);
    @(posedge clk);
    #1;
    drive(1, b0, 1'b0);
    c0 = mk(HW'({$urandom, $urandom}), 1'b1);
    exp_q[0].push_back(c0);
    drive(0, c0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 7) chk("wd_before_limit", 128'(error_o), 128'(0));
      if (i == 8) chk("wd_at_limit", 128'(error_o), 128'(WD));
      if (i == 10) chk("wd_sticky", 128'(error_o), 128'(WD));
      if (i == 5) chk("lock_blocks_req0", 128'(mem_ready_and_o[0]), 128'(0));
    end
    @(posedge clk);
    #1;
    drive(1, b1, 1'b1);
    @(posedge clk);
    #1;
    mem_v_i[1] = 1'b0;
    @(negedge clk);
    chk("req0_after_lock", 128'(mem_ready_and_o[0]), 128'(1));
    @(posedge clk);
    #1;
    mem_v_i = '0;
    @(negedge clk);
    chk("req0_drained", 128'(exp_q[0].size()), 128'(0));
    chk("wd_still_set", 128'(error_o), 128'(WD));

    @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("err_cleared", 128'(error_o), 128'(0));
    chk("ptr_reset", 128'(grant_id_o), 128'(0));
    chk("idle_v_o", 128'(mem_v_o), 128'(0));
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_me_mem_cmd_arbiter.md
# bp_me_mem_cmd_arbiter

Arbitrates N BedRock memory-command streams onto one CCE-memory port (`bp_bedrock_cce_mem_msg_s` header plus data beats). Typical requesters are the CCE, the I/O CCE and the cfg/loopback path sharing one memory-side link. Arbitration is round-robin and message-atomic: once a requester's first beat is accepted, it holds the port until its last beat transfers. The output path is zero-latency; only arbitration state is registered.

## Interface
Parameters:
- `bp_params_p`, `e_bp_default_cfg`: processor config; supplies `paddr_width_p`, `cce_block_width_p`, `lce_id_width_p`, `lce_assoc_p`.
- `num_req_p`, 2: number of requesters, 2..8.
- `data_width_p`, 64: beat data width, 64..`cce_block_width_p`.
- `watchdog_cycles_p`, 1024: stall limit, used only when the watchdog is compiled in.
- Local `lg_num_req_lp` = `BSG_SAFE_CLOG2(num_req_p)`.
- Local `header_width_lp` = `cce_mem_header_width_lp`.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `mem_header_i` in num_req_p*header_width_lp: per-requester header, held constant for all beats of a message.
- `mem_data_i` in num_req_p*data_width_p: per-requester beat data.
- `mem_v_i` in num_req_p: per-requester beat valid.
- `mem_last_i` in num_req_p: marks the final beat of a message.
- `mem_ready_and_o` out num_req_p: per-requester accept.
- `mem_header_o` out header_width_lp: granted header.
- `mem_data_o` out data_width_p: granted data.
- `mem_v_o` out 1: output valid.
- `mem_last_o` out 1: output last-beat marker.
- `mem_ready_and_i` in 1: downstream accept.
- `grant_id_o` out lg_num_req_lp: currently selected requester.
- `error_o` out 1: sticky watchdog error.

## Operation
- States: `e_idle` and `e_lock`.
- Registered state: state, `rr_ptr_r` (lg_num_req_lp), `lock_id_r`, watchdog counter.
- `e_idle`:
  - Winner = first asserted `mem_v_i[k]` scanning from `rr_ptr_r` upward, wrapping modulo num_req_p.
  - `mem_v_o` = OR of `mem_v_i`. Outputs mux from the winner.
  - `mem_ready_and_o[winner]` = `mem_ready_and_i`. All other ready bits are 0.
- A transfer is `mem_v_o & mem_ready_and_i`. On a transfer in `e_idle`:
  - `last` = 1: stay in `e_idle`; `rr_ptr_r` ← (winner+1) mod num_req_p.
  - `last` = 0: go to `e_lock`; `lock_id_r` ← winner.
- `e_lock`:
  - Select is fixed at `lock_id_r`. Valids from other requesters are ignored.
  - A transfer with `last` = 1 returns to `e_idle` and sets `rr_ptr_r` ← (lock_id_r+1) mod num_req_p.
- Locked requester deasserting `mem_v_i` mid-message: this is a protocol bubble. Hold the lock; `mem_v_o` = 0.
- `grant_id_o` = winner in `e_idle`, `lock_id_r` in `e_lock`. It is driven even when `mem_v_o` = 0.
- No request in idle: `mem_v_o` = 0, `grant_id_o` = `rr_ptr_r`.
- Wrap: when the pointer is at num_req_p-1, the next value is 0. Non-power-of-two num_req_p must never produce an out-of-range index.
- Reset mid-message: force `e_idle`, `rr_ptr_r` = 0, clear the lock and watchdog. The partial message is abandoned; the downstream side is reset with it.

## Timing
- Combinational paths:
  - `mem_v_i`/`mem_header_i`/`mem_data_i`/`mem_last_i` → outputs.
  - `mem_ready_and_i` → `mem_ready_and_o`.
  - No flops in the data path.
- Throughput: one beat per cycle. Back-to-back messages from different requesters have no bubble, because the pointer update and the new arbitration overlap at the last-beat edge.
- Reset values (while `reset_i` is high and on the cycle after):
  - state = `e_idle`, `rr_ptr_r` = 0, `error_o` = 0.
  - During reset, `mem_v_o` = 0 and all `mem_ready_and_o` = 0 regardless of inputs.
- The lock takes effect on the cycle after the first-beat transfer.
- `mem_ready_and_o` never depends on `mem_v_i` of the same requester, except through winner selection.

## Configuration
- `BP_ME_MEM_ARB_WATCHDOG_EN` defined:
  - A counter (width `BSG_SAFE_CLOG2(watchdog_cycles_p+1)`) increments each cycle in `e_lock` without a transfer. It clears on any transfer or on return to `e_idle`.
  - When the counter reaches `watchdog_cycles_p`, `error_o` sets and stays set until reset. Arbitration is unaffected.
- Undefined: no counter; `error_o` tied to 0.

## Structure
- Header type comes from the existing `declare_bp_bedrock_mem_if` macros. No new shared struct.
- `bp_me_pkg` gains the enum `bp_me_mem_arb_state_e {e_idle, e_lock}`. It is shared with the planned response demux.
- One sub-module: `bp_me_mem_arb_rr_pick`, a combinational rotate-priority picker with inputs req vector and pointer, outputs winner index and found.

## Test plan
- Single requester, num_req_p=2: req0 sends a 1-beat message while `mem_ready_and_i`=1 → transfer in cycle 0; `rr_ptr_r`=1; `grant_id_o`=0 during the transfer.
- Contention: req0 and req1 both send 1-beat messages continuously, pointer 0 → grants alternate 0,1,0,1 with no idle cycles.
- Lock: req1 starts a 4-beat message; req0 asserts valid at beat 2 → req0 sees `mem_ready_and_o`=0 until req1's last beat; req0 is granted the following cycle.
- Backpressure: `mem_ready_and_i`=0 for 5 cycles mid-message → header and data held stable, no requester acknowledged, grant unchanged.
- Wrap, num_req_p=3: all three always valid → grant order 0,1,2,0,1,2; index 3 never appears.
- Reset mid-message plus watchdog: with `BP_ME_MEM_ARB_WATCHDOG_EN` and `watchdog_cycles_p`=8, the locked requester stalls 8 cycles → `error_o`=1 on cycle 8 and stays set. Then assert `reset_i` for 1 cycle → `error_o`=0, state idle, `rr_ptr_r`=0.
